// File: rtl/sec_tick_timer_if.sv
// Command/status bundle between a lift controller and the seconds timer:
// countdown request and abort in one direction, tick/countdown/watchdog status in the other.
interface sec_tick_timer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] load_sec;
    logic             abort;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remain;
    logic             tick_lost;

    modport master (
        output start, load_sec, abort,
        input  tick, busy, done, remain, tick_lost
    );

    modport slave (
        input  start, load_sec, abort,
        output tick, busy, done, remain, tick_lost
    );
endinterface

// File: rtl/sec_tick_timer.sv
// Brings the divided 1 s square wave into the clk_100MHz domain as a one-cycle tick,
// runs a loadable seconds countdown on those ticks and flags loss of the 1 s source.
module sec_tick_timer #(
    parameter int CNT_W        = 8,
    parameter int TICK_TIMEOUT = 150000000
) (
    input  logic            clk_100MHz,
    input  logic            rst_n,
    input  logic            clk_1s,
    sec_tick_timer_if.slave bus
);

    localparam int WD_W = $clog2(TICK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TICK_TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             prev_reg;
    logic             tick_reg;
    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] remain_reg;
    logic [CNT_W-1:0] remain_next;
    logic [WD_W-1:0]  wd_cnt_reg;
    logic             tick_lost_reg;

    // Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            sync1_reg <= clk_1s;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            tick_reg  <= sync2_reg & ~prev_reg;
        end
    end

    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (bus.start) begin
                    if (bus.load_sec != '0) begin
                        state_next  = ST_RUN;
                        remain_next = bus.load_sec;
                    end else begin
                        state_next  = ST_DONE;
                        remain_next = '0;
                    end
                end
            end
            ST_RUN: begin
                // Abort wins over a coincident tick; start is ignored while running.
                if (bus.abort) begin
                    state_next  = ST_IDLE;
                    remain_next = '0;
                end else if (tick_reg) begin
                    if (remain_reg <= CNT_W'(1)) begin
                        state_next  = ST_DONE;
                        remain_next = '0;
                    end else begin
                        remain_next = remain_reg - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next  = ST_IDLE;
                remain_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            remain_reg <= '0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
        end
    end

    // Watchdog: counts cycles since the last tick, saturates, and latches a fault
    // on the cycle the count reaches the timeout; only a tick or reset clears it.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg    <= '0;
            tick_lost_reg <= 1'b0;
        end else if (tick_reg) begin
            wd_cnt_reg    <= '0;
            tick_lost_reg <= 1'b0;
        end else begin
            if (wd_cnt_reg != WD_MAX) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (wd_cnt_reg == WD_MAX - 1'b1) begin
                tick_lost_reg <= 1'b1;
            end
        end
    end

    assign bus.tick      = tick_reg;
    assign bus.busy      = (state_reg == ST_RUN);
    assign bus.done      = (state_reg == ST_DONE);
    assign bus.remain    = remain_reg;
    assign bus.tick_lost = tick_lost_reg;

endmodule
